alu_cdb_unit: RTL and testbench



---
 rtl/alu_cdb_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_cdb_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cdb_unit.sv
// -----------------------------------------------------------------------------
// alu_cdb_unit
// Integer/branch execution unit fed by the reservation-station issue port.
// Each accepted instruction is evaluated in the issue cycle, and its
// {ROB tag, result} pair is pushed into a small FIFO. The FIFO head is
// broadcast on the CDB update channel (update_RS_*) until the arbiter grants
// the bus.
//
// Configuration macro: ALU_SKID_EN
//   defined   -> QDEPTH = 2. One stalled grant cycle is absorbed without
//                throttling the RS, and accept and pop can overlap.
//   undefined -> QDEPTH = 1. alu_full is high while a result is pending.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rdy                 global enable; low freezes all state (clear still acts)
//   clear               synchronous flush: empties the queue, drops the offer
//   ex_instr_valid      RS offers an instruction this cycle
//   ex_opcode_id[5:0]   op id (encoding listed in the OP_* constants below)
//   ex_vj, ex_vk, ex_A  rs1 value, rs2 value, immediate
//   ex_ROB_pos[3:0]     destination ROB tag
//   cdb_grant           CDB granted to this unit this cycle
//   alu_full            queue full; the RS must not treat its offer as taken
//   update_RS_valid     queue head valid on the CDB
//   update_RS_ROB_pos   head tag (0 when empty)
//   update_RS_val       head result (0 when empty)
//
// All outputs are registers. Their next value is derived from the next queue
// state, so the head appears one edge after it is accepted.
// -----------------------------------------------------------------------------
module alu_cdb_unit #(
`ifdef ALU_SKID_EN
  parameter int QDEPTH = 2
`else
  parameter int QDEPTH = 1
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        ex_instr_valid,
  input  logic [5:0]  ex_opcode_id,
  input  logic [31:0] ex_vj,
  input  logic [31:0] ex_vk,
  input  logic [31:0] ex_A,
  input  logic [3:0]  ex_ROB_pos,
  input  logic        cdb_grant,
  output logic        alu_full,
  output logic        update_RS_valid,
  output logic [3:0]  update_RS_ROB_pos,
  output logic [31:0] update_RS_val
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  // Op ids. I-type forms are even with bit 5 clear (SUB is the only even
  // register form). Branches live in the upper half of the id space.
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_ADDI  = 6'd2;
  localparam logic [5:0] OP_AND   = 6'd3;
  localparam logic [5:0] OP_SUB   = 6'd4;
  localparam logic [5:0] OP_OR    = 6'd5;
  localparam logic [5:0] OP_ANDI  = 6'd6;
  localparam logic [5:0] OP_XOR   = 6'd7;
  localparam logic [5:0] OP_ORI   = 6'd8;
  localparam logic [5:0] OP_SLL   = 6'd9;
  localparam logic [5:0] OP_XORI  = 6'd10;
  localparam logic [5:0] OP_SRL   = 6'd11;
  localparam logic [5:0] OP_SLLI  = 6'd12;
  localparam logic [5:0] OP_SRA   = 6'd13;
  localparam logic [5:0] OP_SRLI  = 6'd14;
  localparam logic [5:0] OP_SLT   = 6'd15;
  localparam logic [5:0] OP_SRAI  = 6'd16;
  localparam logic [5:0] OP_SLTU  = 6'd17;
  localparam logic [5:0] OP_SLTI  = 6'd18;
  localparam logic [5:0] OP_SLTIU = 6'd20;
  localparam logic [5:0] OP_LUI   = 6'd22;
  localparam logic [5:0] OP_JALR  = 6'd24;
  localparam logic [5:0] OP_BEQ   = 6'd32;
  localparam logic [5:0] OP_BNE   = 6'd33;
  localparam logic [5:0] OP_BLT   = 6'd34;
  localparam logic [5:0] OP_BGE   = 6'd35;
  localparam logic [5:0] OP_BLTU  = 6'd36;
  localparam logic [5:0] OP_BGEU  = 6'd37;

  logic [31:0] op_b_s;
  logic [31:0] result_s;
  logic        accept_s;
  logic        pop_s;

  logic [3:0]    tag_mem_q [QDEPTH];
  logic [3:0]    tag_mem_d [QDEPTH];
  logic [31:0]   val_mem_q [QDEPTH];
  logic [31:0]   val_mem_d [QDEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [3:0]    tag_q, tag_d;
  logic [31:0]   val_q, val_d;
  logic          full_q, full_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(QDEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  assign accept_s = rdy && ex_instr_valid && !full_q && !clear;
  assign pop_s    = rdy && valid_q && cdb_grant && !clear;

  // Operand B: the immediate for JALR and I-type ops, rs2 otherwise.
  always_comb begin
    op_b_s = ex_vk;
    if ((ex_opcode_id == OP_JALR) ||
        (!ex_opcode_id[5] && !ex_opcode_id[0] && (ex_opcode_id != OP_SUB))) begin
      op_b_s = ex_A;
    end else begin
      op_b_s = ex_vk;
    end
  end

  // Result datapath; branches compare vj against vk directly.
  always_comb begin
    result_s = 32'd0;
    case (ex_opcode_id)
      OP_ADD, OP_ADDI:   result_s = ex_vj + op_b_s;
      OP_SUB:            result_s = ex_vj - op_b_s;
      OP_AND, OP_ANDI:   result_s = ex_vj & op_b_s;
      OP_OR, OP_ORI:     result_s = ex_vj | op_b_s;
      OP_XOR, OP_XORI:   result_s = ex_vj ^ op_b_s;
      OP_SLL, OP_SLLI:   result_s = ex_vj << op_b_s[4:0];
      OP_SRL, OP_SRLI:   result_s = ex_vj >> op_b_s[4:0];
      OP_SRA, OP_SRAI:   result_s = $unsigned($signed(ex_vj) >>> op_b_s[4:0]);
      OP_SLT, OP_SLTI:   result_s = {31'd0, ($signed(ex_vj) < $signed(op_b_s))};
      OP_SLTU, OP_SLTIU: result_s = {31'd0, (ex_vj < op_b_s)};
      OP_LUI:            result_s = ex_A;
      OP_BEQ:            result_s = {31'd0, (ex_vj == ex_vk)};
      OP_BNE:            result_s = {31'd0, (ex_vj != ex_vk)};
      OP_BLT:            result_s = {31'd0, ($signed(ex_vj) < $signed(ex_vk))};
      OP_BGE:            result_s = {31'd0, ($signed(ex_vj) >= $signed(ex_vk))};
      OP_BLTU:           result_s = {31'd0, (ex_vj < ex_vk)};
      OP_BGEU:           result_s = {31'd0, (ex_vj >= ex_vk)};
      OP_JALR:           result_s = (ex_vj + op_b_s) & ~32'd1;
      default:           result_s = 32'd0;
    endcase
  end

  // Next queue state. The outputs are computed from the *next* head, so a
  // push into an empty queue is visible right after the accepting edge.
  always_comb begin
    tag_mem_d = tag_mem_q;
    val_mem_d = val_mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (accept_s) begin
        tag_mem_d[tail_q] = ex_ROB_pos;
        val_mem_d[tail_q] = result_s;
        tail_d            = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      if (accept_s && !pop_s) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop_s && !accept_s) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
    valid_d = (cnt_d != '0);
    full_d  = (cnt_d == CW'(QDEPTH));
    if (valid_d) begin
      tag_d = tag_mem_d[head_d];
      val_d = val_mem_d[head_d];
    end else begin
      tag_d = 4'd0;
      val_d = 32'd0;
    end
  end

  // State and output registers; reset discards the queue at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        tag_mem_q[i] <= 4'd0;
        val_mem_q[i] <= 32'd0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= 4'd0;
      val_q   <= 32'd0;
      full_q  <= 1'b0;
    end else begin
      tag_mem_q <= tag_mem_d;
      val_mem_q <= val_mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      val_q     <= val_d;
      full_q    <= full_d;
    end
  end

  assign alu_full          = full_q;
  assign update_RS_valid   = valid_q;
  assign update_RS_ROB_pos = tag_q;
  assign update_RS_val     = val_q;

endmodule

// File: tb/tb_alu_cdb_unit.sv
module tb_alu_cdb_unit;
`ifdef ALU_SKID_EN
  localparam int QD = 2;
`else
  localparam int QD = 1;
`endif

  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_ADDI  = 6'd2;
  localparam logic [5:0] OP_AND   = 6'd3;
  localparam logic [5:0] OP_SUB   = 6'd4;
  localparam logic [5:0] OP_OR    = 6'd5;
  localparam logic [5:0] OP_ANDI  = 6'd6;
  localparam logic [5:0] OP_XOR   = 6'd7;
  localparam logic [5:0] OP_ORI   = 6'd8;
  localparam logic [5:0] OP_SLL   = 6'd9;
  localparam logic [5:0] OP_XORI  = 6'd10;
  localparam logic [5:0] OP_SRL   = 6'd11;
  localparam logic [5:0] OP_SLLI  = 6'd12;
  localparam logic [5:0] OP_SRA   = 6'd13;
  localparam logic [5:0] OP_SRLI  = 6'd14;
  localparam logic [5:0] OP_SLT   = 6'd15;
  localparam logic [5:0] OP_SRAI  = 6'd16;
  localparam logic [5:0] OP_SLTU  = 6'd17;
  localparam logic [5:0] OP_SLTI  = 6'd18;
  localparam logic [5:0] OP_SLTIU = 6'd20;
  localparam logic [5:0] OP_LUI   = 6'd22;
  localparam logic [5:0] OP_JALR  = 6'd24;
  localparam logic [5:0] OP_BEQ   = 6'd32;
  localparam logic [5:0] OP_BNE   = 6'd33;
  localparam logic [5:0] OP_BLT   = 6'd34;
  localparam logic [5:0] OP_BGE   = 6'd35;
  localparam logic [5:0] OP_BLTU  = 6'd36;
  localparam logic [5:0] OP_BGEU  = 6'd37;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, ex_instr_valid, cdb_grant;
  logic [5:0]  ex_opcode_id;
  logic [31:0] ex_vj, ex_vk, ex_A;
  logic [3:0]  ex_ROB_pos;
  logic        alu_full, update_RS_valid;
  logic [3:0]  update_RS_ROB_pos;
  logic [31:0] update_RS_val;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] val;
  } ent_t;

  ent_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   last_acc;

  always #5 clk = ~clk;

  alu_cdb_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ex_instr_valid(ex_instr_valid), .ex_opcode_id(ex_opcode_id),
    .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_A(ex_A), .ex_ROB_pos(ex_ROB_pos),
    .cdb_grant(cdb_grant), .alu_full(alu_full),
    .update_RS_valid(update_RS_valid), .update_RS_ROB_pos(update_RS_ROB_pos),
    .update_RS_val(update_RS_val)
  );

  // Reference: instruction semantics written straight from the op list.
  function automatic logic [31:0] ref_result(input logic [5:0] op,
      input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] a);
    logic [31:0] b;
    int signed   sj, sb, sk;
    b  = (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
                     OP_SRAI, OP_SLTI, OP_SLTIU, OP_JALR}) ? a : vk;
    sj = vj; sb = b; sk = vk;
    case (op)
      OP_ADD, OP_ADDI:   return vj + b;
      OP_SUB:            return vj - b;
      OP_AND, OP_ANDI:   return vj & b;
      OP_OR, OP_ORI:     return vj | b;
      OP_XOR, OP_XORI:   return vj ^ b;
      OP_SLL, OP_SLLI:   return vj << (b % 32);
      OP_SRL, OP_SRLI:   return vj >> (b % 32);
      OP_SRA, OP_SRAI:   return 32'(sj >>> (b % 32));
      OP_SLT, OP_SLTI:   return (sj < sb) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU: return (vj < b) ? 32'd1 : 32'd0;
      OP_LUI:            return a;
      OP_BEQ:            return (vj == vk) ? 32'd1 : 32'd0;
      OP_BNE:            return (vj != vk) ? 32'd1 : 32'd0;
      OP_BLT:            return (sj < sk) ? 32'd1 : 32'd0;
      OP_BGE:            return (sj >= sk) ? 32'd1 : 32'd0;
      OP_BLTU:           return (vj < vk) ? 32'd1 : 32'd0;
      OP_BGEU:           return (vj >= vk) ? 32'd1 : 32'd0;
      OP_JALR:           return (vj + a) & 32'hFFFF_FFFE;
      default:           return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, expv);
    end
  endtask

  task automatic check_model();
    logic [3:0]  et;
    logic [31:0] ev;
    et = (exp_q.size() > 0) ? exp_q[0].tag : 4'd0;
    ev = (exp_q.size() > 0) ? exp_q[0].val : 32'd0;
    chk("valid", 32'(update_RS_valid), 32'(exp_q.size() > 0));
    chk("tag",   32'(update_RS_ROB_pos), 32'(et));
    chk("val",   update_RS_val, ev);
    chk("full",  32'(alu_full), 32'(exp_q.size() == QD));
  endtask

  // One clock: predict accept/pop from current inputs, advance, compare.
  task automatic step();
    bit   acc, pop;
    ent_t e;
    acc = rdy && ex_instr_valid && (exp_q.size() < QD) && !clear;
    pop = rdy && (exp_q.size() > 0) && cdb_grant && !clear;
    e.tag = ex_ROB_pos;
    e.val = ref_result(ex_opcode_id, ex_vj, ex_vk, ex_A);
    @(posedge clk);
    if (clear) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
    last_acc = acc;
    #1;
    check_model();
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [31:0] vj,
      input logic [31:0] vk, input logic [31:0] a, input logic [3:0] tag);
    ex_opcode_id = op; ex_vj = vj; ex_vk = vk; ex_A = a; ex_ROB_pos = tag;
  endtask

  // Hold an offer until it is taken (bounded).
  task automatic offer(input logic [5:0] op, input logic [31:0] vj,
      input logic [31:0] vk, input logic [31:0] a, input logic [3:0] tag);
    int n;
    set_instr(op, vj, vk, a, tag);
    ex_instr_valid = 1'b1;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 8) begin
      step();
      n++;
    end
    ex_instr_valid = 1'b0;
    chk("offer_taken", 32'(last_acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    cdb_grant = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      step();
      n++;
    end
    chk("drained", 32'(update_RS_valid), 32'd0);
    cdb_grant = 1'b0;
  endtask

  initial begin
    logic [5:0] ops [0:29];
    int n;
    bit sra_taken;
    ops = '{OP_ADD, OP_ADDI, OP_AND, OP_SUB, OP_OR, OP_ANDI, OP_XOR, OP_ORI,
            OP_SLL, OP_XORI, OP_SRL, OP_SLLI, OP_SRA, OP_SRLI, OP_SLT, OP_SRAI,
            OP_SLTU, OP_SLTI, OP_SLTIU, OP_LUI, OP_JALR, OP_BEQ, OP_BNE, OP_BLT,
            OP_BGE, OP_BLTU, OP_BGEU, 6'd0, 6'd41, 6'd63};

    rst = 1'b1; rdy = 1'b1; clear = 1'b0; ex_instr_valid = 1'b0; cdb_grant = 1'b0;
    set_instr(6'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst = 1'b0;

    // ADDI wrap-around, grant held: visible next cycle, retires on that edge.
    cdb_grant = 1'b1;
    offer(OP_ADDI, 32'hFFFF_FFFF, 32'd0, 32'd1, 4'd5);
    chk("addi_valid", 32'(update_RS_valid), 32'd1);
    chk("addi_tag", 32'(update_RS_ROB_pos), 32'd5);
    chk("addi_val", update_RS_val, 32'h0000_0000);
    step();
    chk("addi_retired", 32'(update_RS_valid), 32'd0);

    // SUB then SRA with grant withheld, then strict FIFO retirement.
    cdb_grant = 1'b0;
    offer(OP_SUB, 32'd7, 32'd9, 32'd0, 4'd1);
    chk("sub_tag", 32'(update_RS_ROB_pos), 32'd1);
    chk("sub_val", update_RS_val, 32'hFFFF_FFFE);
    set_instr(OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 4'd2);
    ex_instr_valid = 1'b1;
    step();
    sra_taken = last_acc;
    chk("full_stalled", 32'(alu_full), 32'd1);
    step();
    sra_taken = sra_taken | last_acc;
    chk("head_held", 32'(update_RS_ROB_pos), 32'd1);
    cdb_grant = 1'b1;
    n = 0;
    while (!sra_taken && n < 6) begin
      step();
      sra_taken = last_acc;
      n++;
    end
    ex_instr_valid = 1'b0;
    n = 0;
    while (update_RS_ROB_pos != 4'd2 && n < 6) begin
      step();
      n++;
    end
    chk("sra_tag", 32'(update_RS_ROB_pos), 32'd2);
    chk("sra_val", update_RS_val, 32'hF800_0000);
    drain();

    // Branch compares and JALR.
    offer(OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd3);
    chk("bltu_val", update_RS_val, 32'd1);
    drain();
    offer(OP_BLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd4);
    chk("blt_val", update_RS_val, 32'd0);
    drain();
    offer(OP_JALR, 32'h0000_1001, 32'd0, 32'd4, 4'd7);
    chk("jalr_val", update_RS_val, 32'h0000_1004);
    drain();

    // Full queue flushed while an offer is present.
    for (int i = 0; i < QD; i++) offer(OP_ADD, 32'(i), 32'd10, 32'd0, 4'(8 + i));
    chk("full_before_clear", 32'(alu_full), 32'd1);
    set_instr(OP_OR, 32'hF0, 32'h0F, 32'd0, 4'd9);
    ex_instr_valid = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    ex_instr_valid = 1'b0;
    chk("clear_valid", 32'(update_RS_valid), 32'd0);
    chk("clear_val", update_RS_val, 32'd0);
    chk("clear_full", 32'(alu_full), 32'd0);
    cdb_grant = 1'b1;
    repeat (3) step();
    cdb_grant = 1'b0;

    // rdy low freezes a valid head even with grant high.
    offer(OP_ADD, 32'd3, 32'd4, 32'd0, 4'd6);
    rdy = 1'b0;
    cdb_grant = 1'b1;
    set_instr(OP_XOR, 32'd1, 32'd2, 32'd0, 4'd11);
    ex_instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frozen_tag", 32'(update_RS_ROB_pos), 32'd6);
      chk("frozen_val", update_RS_val, 32'd7);
    end
    ex_instr_valid = 1'b0;
    rdy = 1'b1;
    step();
    chk("resumed_retire", 32'(update_RS_valid), 32'd0);
    cdb_grant = 1'b0;

    // Asynchronous reset mid-cycle with the queue full.
    for (int i = 0; i < QD; i++) offer(OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 4'(12 + i));
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_valid", 32'(update_RS_valid), 32'd0);
    chk("arst_tag", 32'(update_RS_ROB_pos), 32'd0);
    chk("arst_val", update_RS_val, 32'd0);
    chk("arst_full", 32'(alu_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] vj, vk;
      vj = $urandom;
      vk = ($urandom_range(0, 3) == 0) ? vj : $urandom;
      if ($urandom_range(0, 2) == 0) begin
        vj = 32'($urandom_range(0, 40));
        vk = 32'($urandom_range(0, 40));
      end
      set_instr(ops[$urandom_range(0, 29)], vj, vk, $urandom, 4'($urandom_range(0, 15)));
      ex_instr_valid = ($urandom_range(0, 3) != 0);
      cdb_grant      = ($urandom_range(0, 2) != 0);
      rdy            = ($urandom_range(0, 7) != 0);
      clear          = ($urandom_range(0, 19) == 0);
      step();
    end
    clear = 1'b0;
    rdy = 1'b1;
    ex_instr_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
